// File: rtl/menu_textmenu_nav.sv
// -----------------------------------------------------------------------------
// menu_textmenu_nav
//
// Navigable text menu for the character-mode VGA overlay. Maps the character
// grid position coming from the font/char pipeline to a 7-bit character code,
// keeps a cursor driven by up/down/enter keys, marks the cursor row for inverse
// video and raises a valid/ready selection request towards game control.
//
// Character codes are 7-bit ASCII: SPACE 0x20, NKL '[' 0x5B, NKR ']' 0x5D,
// digits 0x30.., uppercase letters 0x41...
//
// Parameters:
//   N_ITEMS    number of menu rows (1..9)
//   COLS       characters per row (5..16)
//   WRAP       1 = cursor wraps at the ends, 0 = cursor saturates
//   BLINK_DIV  clk cycles per blink half-period (only with MENU_BLINK_EN)
//
// Optional feature macro: MENU_BLINK_EN -- cursor row blinks while idle and is
//   shown steady while a selection request is pending.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   char_xy    [7:4] row, [3:0] column of the character being fetched
//   key_up     synchronised level, active-high
//   key_down   synchronised level, active-high
//   key_enter  synchronised level, active-high
//   sel_ready  consumer accepts the selection
//   char_code  character code, registered (1 cycle after char_xy)
//   char_inv   render inverted (cursor highlight), registered
//   sel_valid  selection request pending
//   sel_idx    selected item index, stable while sel_valid=1
//   cur_idx    current cursor index
// -----------------------------------------------------------------------------
module menu_textmenu_nav #(
    parameter int N_ITEMS   = 4,
    parameter int COLS      = 16,
    parameter int WRAP      = 1,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_xy,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_enter,
    input  logic       sel_ready,
    output logic [6:0] char_code,
    output logic       char_inv,
    output logic       sel_valid,
    output logic [3:0] sel_idx,
    output logic [3:0] cur_idx
);

    localparam logic [6:0] CH_SPACE  = 7'h20;
    localparam logic [6:0] CH_NKL    = 7'h5B;
    localparam logic [6:0] CH_NKR    = 7'h5D;
    localparam logic [6:0] CH_DIGIT0 = 7'h30;

    localparam logic [3:0] LAST_IDX = 4'(N_ITEMS - 1);
    localparam logic [4:0] N_LIM    = 5'(N_ITEMS);
    localparam logic [4:0] COLS_LIM = 5'(COLS);

    // Labels occupy columns 4..15, 12 characters each, padded with spaces.
    localparam logic [95:0] LABEL_0 = "GRAJ        ";
    localparam logic [95:0] LABEL_1 = "FABULA      ";
    localparam logic [95:0] LABEL_2 = "O GRZE      ";
    localparam logic [95:0] LABEL_3 = "STEROWANIE  ";
    localparam logic [95:0] LABEL_BLANK = "            ";

    if (N_ITEMS < 1 || N_ITEMS > 9 || COLS < 5 || COLS > 16 || BLINK_DIV < 1) begin : g_bad_param
        $error("menu_textmenu_nav: parameter out of range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cur_reg, cur_next;
    logic [3:0] sel_reg, sel_next;

    // ---------------------------------------------------------------------
    // Key edge detection. Bit 0 = up, 1 = down, 2 = enter.
    // rst_hold_reg suppresses edges on the first cycle after reset so a key
    // held through reset is absorbed into the previous-level register.
    // ---------------------------------------------------------------------
    logic [2:0] key_vec;
    logic [2:0] key_prev_reg;
    logic [2:0] key_edge_reg;
    logic       rst_hold_reg;

    assign key_vec = {key_enter, key_down, key_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_hold_reg <= 1'b1;
        end else begin
            rst_hold_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_key_edge
        always_ff @(posedge clk) begin
            if (rst) begin
                key_prev_reg[gi] <= 1'b0;
                key_edge_reg[gi] <= 1'b0;
            end else begin
                key_prev_reg[gi] <= key_vec[gi];
                key_edge_reg[gi] <= key_vec[gi] & ~key_prev_reg[gi] & ~rst_hold_reg;
            end
        end
    end

    logic up_edge, down_edge, enter_edge;
    assign up_edge    = key_edge_reg[0];
    assign down_edge  = key_edge_reg[1];
    assign enter_edge = key_edge_reg[2];

    // ---------------------------------------------------------------------
    // Cursor / selection FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cur_reg   <= 4'd0;
            sel_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            sel_reg   <= sel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                // Enter wins over movement; simultaneous up+down cancel out.
                if (enter_edge) begin
                    state_next = REQ;
                    sel_next   = cur_reg;
                end else if (up_edge && !down_edge) begin
                    if (cur_reg == 4'd0) begin
                        cur_next = (WRAP != 0) ? LAST_IDX : 4'd0;
                    end else begin
                        cur_next = cur_reg - 4'd1;
                    end
                end else if (down_edge && !up_edge) begin
                    if (cur_reg == LAST_IDX) begin
                        cur_next = (WRAP != 0) ? 4'd0 : LAST_IDX;
                    end else begin
                        cur_next = cur_reg + 4'd1;
                    end
                end
            end
            REQ: begin
                // Key edges are dropped here; only the handshake matters.
                if (sel_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_valid = (state_reg == REQ);
    assign sel_idx   = sel_reg;
    assign cur_idx   = cur_reg;

    // ---------------------------------------------------------------------
    // Text generation
    // ---------------------------------------------------------------------
    logic [3:0]  row, col;
    logic [95:0] label_row;
    logic [6:0]  label_char;
    logic [6:0]  code_next;
    logic        hl;
    logic        inv_next;
    int          label_pos;

    assign row = char_xy[7:4];
    assign col = char_xy[3:0];

    always_comb begin
        label_row = LABEL_BLANK;
        case (row)
            4'd0:    label_row = LABEL_0;
            4'd1:    label_row = LABEL_1;
            4'd2:    label_row = LABEL_2;
            4'd3:    label_row = LABEL_3;
            default: label_row = LABEL_BLANK;
        endcase
        label_pos  = (col >= 4'd4) ? (int'(col) - 4) : 0;
        // Leftmost label character sits in the top byte of the string.
        label_char = label_row[8 * (11 - label_pos) +: 7];
    end

    always_comb begin
        code_next = CH_SPACE;
        if ({1'b0, row} < N_LIM && {1'b0, col} < COLS_LIM) begin
            case (col)
                4'd0:    code_next = CH_NKL;
                4'd1:    code_next = CH_DIGIT0 + {3'b000, row} + 7'd1;
                4'd2:    code_next = CH_NKR;
                4'd3:    code_next = CH_SPACE;
                default: code_next = label_char;
            endcase
        end
    end

    // cur_reg is always < N_ITEMS, so a row match implies a valid menu row.
    assign hl = (row == cur_reg) && ({1'b0, col} < COLS_LIM);

`ifdef MENU_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_reg;
    logic          blink_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            blink_reg     <= ~blink_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Pending selection shows a steady highlight as confirmation.
    assign inv_next = hl & (blink_reg | (state_reg == REQ));
`else
    assign inv_next = hl;
`endif

    logic [6:0] char_code_reg;
    logic       char_inv_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            char_code_reg <= 7'd0;
            char_inv_reg  <= 1'b0;
        end else begin
            char_code_reg <= code_next;
            char_inv_reg  <= inv_next;
        end
    end

    assign char_code = char_code_reg;
    assign char_inv  = char_inv_reg;

endmodule

// File: tb/tb_menu_textmenu_nav.sv
`timescale 1ns/1ps
// Scoreboard bench for menu_textmenu_nav. Two instances share the inputs:
// dut0 uses the defaults (4 items, 16 cols, wrap), dut1 uses 3 items,
// 5 cols, saturating cursor. A reference model built from the menu rules
// predicts each cycle's outputs and each selection handshake.
module tb_menu_textmenu_nav;

    localparam int BDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_xy = 8'h00;
    logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0, sel_ready = 1'b0;

    logic [6:0] code0, code1;
    logic       inv0, inv1, val0, val1;
    logic [3:0] sidx0, sidx1, cidx0, cidx1;

    always #5 clk = ~clk;

    menu_textmenu_nav #(.N_ITEMS(4), .COLS(16), .WRAP(1), .BLINK_DIV(BDIV)) dut0 (
        .clk(clk), .rst(rst), .char_xy(char_xy),
        .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
        .sel_ready(sel_ready),
        .char_code(code0), .char_inv(inv0), .sel_valid(val0),
        .sel_idx(sidx0), .cur_idx(cidx0)
    );

    menu_textmenu_nav #(.N_ITEMS(3), .COLS(5), .WRAP(0), .BLINK_DIV(BDIV)) dut1 (
        .clk(clk), .rst(rst), .char_xy(char_xy),
        .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
        .sel_ready(sel_ready),
        .char_code(code1), .char_inv(inv1), .sel_valid(val1),
        .sel_idx(sidx1), .cur_idx(cidx1)
    );

    // ---------------- reference model ----------------
    int    p_n [2] = '{4, 3};
    int    p_c [2] = '{16, 5};
    int    p_w [2] = '{1, 0};
    string labels [0:8] = '{"GRAJ", "FABULA", "O GRZE", "STEROWANIE", "", "", "", "", ""};

    int m_cur [2];
    int m_sel [2];
    bit m_req [2];
    bit m_eu, m_ed, m_ee, m_pu, m_pd, m_pe, m_first;
    int m_k;

    typedef struct packed {
        logic [6:0] code0;
        logic [6:0] code1;
        logic       inv0;
        logic       inv1;
        logic [3:0] cur0;
        logic [3:0] cur1;
        logic [3:0] sel0;
        logic [3:0] sel1;
        logic       val0;
        logic       val1;
    } exp_t;

    exp_t exp_q[$];
    int   sel_q0[$];
    int   sel_q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_char(input int inst, input int xy);
        int    r, c;
        string s;
        byte   b;
        r = xy / 16;
        c = xy % 16;
        if (r >= p_n[inst] || c >= p_c[inst]) return 7'h20;
        if (c == 0) return 7'h5B;
        if (c == 1) return 7'(32'h31 + r);
        if (c == 2) return 7'h5D;
        if (c == 3) return 7'h20;
        s = labels[r];
        if (c - 4 >= s.len()) return 7'h20;
        b = s[c - 4];
        return b[6:0];
    endfunction

    // Drive one cycle of inputs and predict the state after the next edge.
    task automatic step(input logic r, input logic [7:0] xy, input logic u, input logic d,
                        input logic e, input logic rd);
        exp_t       x;
        logic [6:0] code [2];
        logic       inv  [2];
        int         row, col;
        bit         hl;
        @(negedge clk);
        rst = r; char_xy = xy; key_up = u; key_down = d; key_enter = e; sel_ready = rd;
        code[0] = 7'd0; code[1] = 7'd0; inv[0] = 1'b0; inv[1] = 1'b0;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_cur[i] = 0; m_sel[i] = 0; m_req[i] = 1'b0;
            end
            m_eu = 0; m_ed = 0; m_ee = 0; m_pu = 0; m_pd = 0; m_pe = 0;
            m_first = 1; m_k = 0;
            sel_q0.delete();
            sel_q1.delete();
        end else begin
            row = int'(xy) / 16;
            col = int'(xy) % 16;
            for (int i = 0; i < 2; i++) begin
                hl = (row == m_cur[i]) && (col < p_c[i]);
`ifdef MENU_BLINK_EN
                inv[i] = hl && ((((m_k / BDIV) % 2) == 0) || m_req[i]);
`else
                inv[i] = hl;
`endif
                code[i] = exp_char(i, int'(xy));
                if (!m_req[i]) begin
                    if (m_ee) begin
                        m_req[i] = 1'b1;
                        m_sel[i] = m_cur[i];
                        if (i == 0) sel_q0.push_back(m_cur[i]);
                        else        sel_q1.push_back(m_cur[i]);
                    end else if (m_eu && !m_ed) begin
                        if (m_cur[i] == 0) m_cur[i] = (p_w[i] != 0) ? p_n[i] - 1 : 0;
                        else m_cur[i] = m_cur[i] - 1;
                    end else if (m_ed && !m_eu) begin
                        if (m_cur[i] == p_n[i] - 1) m_cur[i] = (p_w[i] != 0) ? 0 : p_n[i] - 1;
                        else m_cur[i] = m_cur[i] + 1;
                    end
                end else if (rd) begin
                    m_req[i] = 1'b0;
                end
            end
            m_eu = !m_first && u && !m_pu;
            m_ed = !m_first && d && !m_pd;
            m_ee = !m_first && e && !m_pe;
            m_pu = u; m_pd = d; m_pe = e;
            m_first = 0;
            m_k++;
        end
        x.code0 = code[0];  x.code1 = code[1];
        x.inv0  = inv[0];   x.inv1  = inv[1];
        x.cur0  = 4'(m_cur[0]); x.cur1 = 4'(m_cur[1]);
        x.sel0  = 4'(m_sel[0]); x.sel1 = 4'(m_sel[1]);
        x.val0  = m_req[0]; x.val1  = m_req[1];
        exp_q.push_back(x);
    endtask

    function automatic logic [7:0] rx();
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- monitors ----------------
    // Per-cycle outputs: compared just after the edge that produced them.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("code0", {1'b0, code0}, {1'b0, e.code0});
                check("inv0",  {7'd0, inv0},  {7'd0, e.inv0});
                check("cur0",  {4'd0, cidx0}, {4'd0, e.cur0});
                check("valid0",{7'd0, val0},  {7'd0, e.val0});
                check("sidx0", {4'd0, sidx0}, {4'd0, e.sel0});
                check("code1", {1'b0, code1}, {1'b0, e.code1});
                check("inv1",  {7'd0, inv1},  {7'd0, e.inv1});
                check("cur1",  {4'd0, cidx1}, {4'd0, e.cur1});
                check("valid1",{7'd0, val1},  {7'd0, e.val1});
                check("sidx1", {4'd0, sidx1}, {4'd0, e.sel1});
            end
        end
    end

    // Selection handshakes: sampled mid-cycle, before the completing edge.
    initial begin
        int ex;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b0 && sel_ready === 1'b1) begin
                if (val0 === 1'b1) begin
                    if (sel_q0.size() == 0) begin
                        check("hs0_unexpected", 8'd1, 8'd0);
                    end else begin
                        ex = sel_q0.pop_front();
                        check("hs0_idx", {4'd0, sidx0}, 8'(ex));
                        $display("[TB] dut0 selection transfer idx=%0d", sidx0);
                    end
                end
                if (val1 === 1'b1) begin
                    if (sel_q1.size() == 0) begin
                        check("hs1_unexpected", 8'd1, 8'd0);
                    end else begin
                        ex = sel_q1.pop_front();
                        check("hs1_idx", {4'd0, sidx1}, 8'(ex));
                        $display("[TB] dut1 selection transfer idx=%0d", sidx1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic u, d, e, rd, r;
        // Reset with enter held through it: no request may follow.
        repeat (3) step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full grid sweep.
        for (int i = 0; i < 256; i++) step(1'b0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);

        // Up pulse at 0 (dut0 wraps, dut1 saturates), then down pulse.
        step(1'b0, rx(), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, rx(), 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b0);

        // Down held for 100 cycles: one step only.
        repeat (100) step(1'b0, rx(), 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b0);

        // Up and down rising together: no move.
        step(1'b0, rx(), 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b0);

        // Cursor to 2, enter without ready, downs ignored in REQ, then accept.
        step(1'b0, rx(), 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            step(1'b0, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        repeat (6) step(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while a request is pending.
        step(1'b0, rx(), 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, rx(), 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, rx(), 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic.
        u = 0; d = 0; e = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) u = ~u;
            if ($urandom_range(0, 3) == 0) d = ~d;
            if ($urandom_range(0, 5) == 0) e = ~e;
            rd = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 299) == 0);
            step(r, rx(), u, d, e, rd);
        end

        // Drain any pending request.
        repeat (10) step(1'b0, rx(), 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("exp_q_left", 8'(exp_q.size()), 8'd0);
        check("sel_q0_left", 8'(sel_q0.size()), 8'd0);
        check("sel_q1_left", 8'(sel_q1.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/menu_textmenu_nav.md
# menu_textmenu_nav

Parametrised, navigable text menu for the character-mode VGA overlay. It maps the character-grid position from the font/char pipeline to a 7-bit `vga_pkg` character code. It tracks a cursor (selected item) driven by up/down/enter keys, flags the cursor row for inverse video, and issues a valid/ready selection request to the game-control logic. It replaces the fixed 4-item menu ROM.

## Interface
Parameters:
- N_ITEMS, 4, number of menu rows; legal 1..9.
- COLS, 16, characters per row; legal 5..16.
- WRAP, 1, 1 = cursor wraps at ends; 0 = cursor saturates.
- BLINK_DIV, 25_000_000, clk cycles per blink half-period (used only with MENU_BLINK_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- char_xy  in  8  [7:4] row, [3:0] column of the character being fetched.
- key_up  in  1  synchronised level, active-high.
- key_down  in  1  synchronised level, active-high.
- key_enter  in  1  synchronised level, active-high.
- sel_ready  in  1  consumer accepts the selection.
- char_code  out  7  character code (`vga_pkg` constant).
- char_inv  out  1  render this character inverted (cursor highlight).
- sel_valid  out  1  selection request pending.
- sel_idx  out  4  selected item index, 0-based; stable while sel_valid=1.
- cur_idx  out  4  current cursor index.

## Operation
- Text: row r < N_ITEMS, col c < COLS:
  - c0 = NKL, c1 = digit C_(r+1), c2 = NKR, c3 = SPACE.
  - c4.. = label. Labels: item0 "GRAJ", item1 "FABULA", item2 "O GRZE", item3 "STEROWANIE"; items 4..8 blank.
  - Label chars past the label end are SPACE.
- Row ≥ N_ITEMS or col ≥ COLS: char_code = SPACE, char_inv = 0.
- Highlight: char_inv = 1 iff row == cur_idx and col < COLS.
- Key handling: one-cycle rising-edge pulse per key, using registered previous levels. Levels held high produce exactly one action.
- FSM with states IDLE and REQ.
  - IDLE, up edge: cur_idx−1. At 0 it becomes N_ITEMS−1 if WRAP, else stays 0.
  - IDLE, down edge: cur_idx+1. At N_ITEMS−1 it becomes 0 if WRAP, else stays put.
  - IDLE, up and down edges in the same cycle: no move.
  - IDLE, enter edge: go to REQ; sel_idx ← cur_idx; sel_valid = 1. Enter has priority over up/down in the same cycle; the cursor does not move.
  - REQ: sel_valid = 1, sel_idx held. All key edges are discarded, including enter (no queueing).
  - REQ with sel_ready = 1: transfer completes; next cycle IDLE, sel_valid = 0.
- sel_ready is ignored in IDLE.

## Timing
- char_code and char_inv are registered: 1-cycle latency from char_xy. char_inv reflects cur_idx as it was when the grid position was sampled.
- Key edge to cur_idx update: 2 cycles (1 cycle for edge detect, 1 cycle for the register).
- Key edge to sel_valid high: 2 cycles.
- Handshake completes on the cycle where sel_valid & sel_ready are both 1. sel_valid falls on the next edge.
- Reset values: char_code = 0, char_inv = 0, sel_valid = 0, sel_idx = 0, cur_idx = 0, FSM = IDLE, edge registers = 0, blink counter = 0.
- Reset mid-REQ drops the request with no transfer.
- A key held high through reset does not produce an edge after reset, because the edge registers reload from the key on the first cycle out of reset.

## Configuration
- MENU_BLINK_EN defined:
  - A counter of width ⌈log2 BLINK_DIV⌉ toggles a blink flag every BLINK_DIV cycles.
  - char_inv = highlight & blink flag, so the cursor row flashes.
  - While in REQ the highlight is forced steady (char_inv = highlight) to confirm the selection.
  - The blink flag resets to 1.
- MENU_BLINK_EN not defined: no counter; char_inv = highlight at all times; BLINK_DIV is unused.

## Test plan
- Reset, then sweep char_xy 0x00..0xFF with defaults:
  - 0x00..0x03 → NKL, C_1, NKR, SPACE.
  - 0x34..0x3D → "STEROWANIE".
  - 0x40 → SPACE.
  - char_inv = 1 only for 0x00..0x0F.
  - Outputs lag char_xy by 1 cycle.
- WRAP=1, up pulse from cur_idx=0 → cur_idx=3 two cycles later. Down pulse → 0. With WRAP=0, up at 0 → stays 0.
- key_down held high 100 cycles → cur_idx advances by exactly 1. Up and down rising together → cur_idx unchanged.
- Cursor at 2, then enter with sel_ready=0 → sel_valid=1, sel_idx=2. Down pulses during REQ are ignored. sel_ready=1 for 1 cycle → sel_valid=0 next cycle, cur_idx still 2.
- Assert rst while in REQ → all outputs return to reset values the next cycle. Enter held through reset → no request issued.
- MENU_BLINK_EN with BLINK_DIV=4:
  - Probing cursor row → char_inv toggles every 4 cycles.
  - During REQ → char_inv steady at 1.
